// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_updown_counter
//
// Synchronous up/down modulo counter with parallel load, synchronous clear,
// wrap-or-saturate behaviour at the range ends, a combinational terminal-count
// output, a one-cycle wrap event pulse and a sticky overflow flag.
//
// The count always stays inside 0..MODULUS-1. Arithmetic is modulo MODULUS,
// not modulo 2**WIDTH.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//   MODULUS  : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset (count/wrap/ovf -> 0)
//   clear    : synchronous clear of count and ovf
//   load     : parallel load of load_val (clamped to MODULUS-1, sets ovf)
//   load_val : value to load
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   count    : registered count
//   count_n  : bitwise complement of count
//   tc       : terminal count for the current direction (combinational)
//   wrap     : one-cycle pulse after a boundary count
//   ovf      : sticky overflow / saturation flag
//
// Update priority at each edge: reset_n=0 > clear > load > en > hold.
// ---------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Highest legal count value.
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);
  // MODULUS may equal 2**WIDTH, so the load range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;
  logic             at_end;
  logic             load_in_range;

  // Terminal value for the direction sampled this cycle.
  assign at_end        = up ? (count_q == LAST_VAL) : (count_q == '0);
  assign load_in_range = ({1'b0, load_val} < MOD_EXT);

  // Next-state logic.
  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      if (load_in_range) begin
        count_d = load_val;
      end else begin
        count_d = LAST_VAL;
        ovf_d   = 1'b1;
      end
    end else if (en) begin
      if (at_end) begin
        // Boundary count: flag it, then either wrap around or hold.
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        if (SATURATE == 1'b0) begin
          count_d = up ? '0 : LAST_VAL;
        end
      end else begin
        count_d = up ? (count_q + 1'b1) : (count_q - 1'b1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // tc is forced low while reset is asserted and whenever clear/load would
  // override the count on the coming edge.
  assign tc      = reset_n & en & ~clear & ~load & at_end;
  assign count   = count_q;
  assign count_n = ~count_q;
  assign wrap    = wrap_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Drives one stimulus stream into two counters (WIDTH=4, MODULUS=10), one in
// wrap mode and one in saturate mode, and compares both against an integer
// reference model. Directed sequences cover reset, wrap up/down, saturation,
// load/clear priority and direction toggling; a random phase follows.
// ---------------------------------------------------------------------------
module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset_n, clear, load, en, up;
  logic [W-1:0] load_val;

  logic [W-1:0] count_w, count_n_w, count_s, count_n_s;
  logic         tc_w, wrap_w, ovf_w, tc_s, wrap_s, ovf_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, index 0 = wrap mode, index 1 = saturate mode.
  int m_count [2];
  int m_wrap  [2];
  int m_ovf   [2];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .count(count_w), .count_n(count_n_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .count(count_s), .count_n(count_n_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected terminal count from the current inputs and a model count.
  function automatic int model_tc(input int c);
    int at_end;
    at_end = up ? (c == M - 1) : (c == 0);
    return (reset_n && en && !clear && !load && at_end) ? 1 : 0;
  endfunction

  // One clock edge of the behavioural model, written from the counting rules.
  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      if (!reset_n || clear) begin
        m_count[s] = 0;
        m_wrap[s]  = 0;
        m_ovf[s]   = 0;
      end else if (load) begin
        m_wrap[s] = 0;
        if (int'(load_val) < M) begin
          m_count[s] = int'(load_val);
        end else begin
          m_count[s] = M - 1;
          m_ovf[s]   = 1;
        end
      end else if (en) begin
        if ((up && m_count[s] == M - 1) || (!up && m_count[s] == 0)) begin
          m_wrap[s] = 1;
          m_ovf[s]  = 1;
          if (s == 0) m_count[s] = (m_count[s] + (up ? 1 : M - 1)) % M;
        end else begin
          m_wrap[s]  = 0;
          m_count[s] = m_count[s] + (up ? 1 : -1);
        end
      end else begin
        m_wrap[s] = 0;
      end
    end
  endtask

  task automatic check_regs();
    check("wrap_mode.count",   int'(count_w),   m_count[0]);
    check("wrap_mode.count_n", int'(count_n_w), (~m_count[0]) & 'hF);
    check("wrap_mode.wrap",    int'(wrap_w),    m_wrap[0]);
    check("wrap_mode.ovf",     int'(ovf_w),     m_ovf[0]);
    check("sat_mode.count",    int'(count_s),   m_count[1]);
    check("sat_mode.count_n",  int'(count_n_s), (~m_count[1]) & 'hF);
    check("sat_mode.wrap",     int'(wrap_s),    m_wrap[1]);
    check("sat_mode.ovf",      int'(ovf_s),     m_ovf[1]);
  endtask

  // Apply inputs just after a falling edge, check tc combinationally, then
  // advance one rising edge and check the registered outputs on the next
  // falling edge.
  task automatic step(input logic rn, input logic clr, input logic ld,
                      input logic [W-1:0] lv, input logic e, input logic u);
    reset_n  = rn;
    clear    = clr;
    load     = ld;
    load_val = lv;
    en       = e;
    up       = u;
    #1;
    check("wrap_mode.tc", int'(tc_w), model_tc(m_count[0]));
    check("sat_mode.tc",  int'(tc_s), model_tc(m_count[1]));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_count[s] = 0; m_wrap[s] = 0; m_ovf[s] = 0;
    end
    @(negedge clk);

    // Reset, then count to 9 and reset mid-count with en/up still high.
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("reset.count_n", int'(count_n_w), 15);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("run_to_9", int'(count_w), 9);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("mid_reset.count", int'(count_w), 0);
    check("mid_reset.ovf",   int'(ovf_w),   0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("post_reset.count", int'(count_w), 1);

    // Wrap / saturate going up: 10 edges from 0, then 3 more.
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("wrap_up.count", int'(count_w), 0);
    check("wrap_up.wrap",  int'(wrap_w),  1);
    check("sat_up.count",  int'(count_s), 9);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("sat_hold.count", int'(count_s), 9);
    check("sat_hold.wrap",  int'(wrap_s),  1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("sat_down.count", int'(count_s), 8);

    // Wrap down from 0, then clear.
    step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("wrap_down.count", int'(count_w), 9);
    check("wrap_down.ovf",   int'(ovf_w),   1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("clear.ovf", int'(ovf_w), 0);

    // Load priority cases.
    step(1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    check("load_oor.count", int'(count_w), 9);
    check("load_oor.ovf",   int'(ovf_w),   1);
    step(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    check("clear_beats_load", int'(count_w), 0);
    step(1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1);
    check("clear_oor_load.ovf", int'(ovf_w), 0);
    step(1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    check("load_beats_en", int'(count_w), 5);
    step(1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    check("load_at_boundary.wrap", int'(wrap_w), 0);

    // Direction toggling from 5.
    step(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, (i % 2) == 0);
    check("toggle.count", int'(count_w), 5);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 5,
           $urandom_range(99) < 10,
           W'($urandom_range(15)),
           $urandom_range(99) < 75,
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
